fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the femtoRV32 cores. It replaces the fixed PC register and zero-latency instruction ROM path with three things: a PC generator, a request/grant instruction-memory interface tolerating variable latency, and a QDEPTH-entry in-order fetch queue with a valid/ready handshake toward decode. Taken branches and jumps redirect it, flushing the queue and discarding wrong-path responses still in flight.

---
 rtl/fetch_unit.sv | 173 +++++++++++++++++
 tb/tb_fetch_unit.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: PC generator, req/gnt instruction-memory port and in-order fetch queue.
// Define FETCH_PERF_CNT_EN to add the perf_fetched / perf_flushes counters.
module fetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              QDEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_flushes
`endif
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] QLIM = (CW+1)'(QDEPTH);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    // Fetch PC and queue bookkeeping
    logic [XLEN-1:0] pc_q, pc_d;
    ptr_t            head_q, head_d;
    ptr_t            tail_q, tail_d;
    ptr_t            fill_q, fill_d;
    cnt_t            occ_q, occ_d;
    cnt_t            pend_q, pend_d;
    cnt_t            drop_q, drop_d;

    // Queue storage
    logic [XLEN-1:0]   ent_pc_q [QDEPTH];
    logic [XLEN-1:0]   ent_pc_d [QDEPTH];
    logic [31:0]       ent_data_q [QDEPTH];
    logic [31:0]       ent_data_d [QDEPTH];
    logic [QDEPTH-1:0] ent_filled_q, ent_filled_d;

    logic [CW:0] inflight;
    logic        grant;
    logic        rsp_drop;
    logic        rsp_fill;
    logic        rsp_take;
    logic        pop;
    logic        unused_lo;

    // Byte offset of a redirect target is meaningless for word fetches
    assign unused_lo = ^redirect_pc[1:0];

    // Outputs are functions of registered state only
    assign inflight   = {1'b0, occ_q} + {1'b0, drop_q};
    assign imem_req   = inflight < QLIM;
    assign imem_addr  = pc_q;
    assign inst_valid = (occ_q != '0) & ent_filled_q[head_q];
    assign inst       = ent_data_q[head_q];
    assign inst_pc    = ent_pc_q[head_q];

    // Events of this cycle
    assign grant    = imem_req & imem_gnt;
    assign rsp_drop = imem_rvalid & (drop_q != '0);
    assign rsp_fill = imem_rvalid & (drop_q == '0) & (pend_q != '0);
    assign rsp_take = rsp_drop | rsp_fill;
    assign pop      = inst_valid & inst_ready;

    // Next-state: allocate on grant, fill oldest unfilled, free head, redirect overrides
    always_comb begin
        pc_d         = pc_q;
        head_d       = head_q;
        tail_d       = tail_q;
        fill_d       = fill_q;
        ent_pc_d     = ent_pc_q;
        ent_data_d   = ent_data_q;
        ent_filled_d = ent_filled_q;

        if (grant) begin
            ent_pc_d[tail_q]     = pc_q;
            ent_filled_d[tail_q] = 1'b0;
            tail_d               = tail_q + ptr_t'(1);
            pc_d                 = pc_q + XLEN'(4);
        end

        if (rsp_fill) begin
            ent_data_d[fill_q]   = imem_rdata;
            ent_filled_d[fill_q] = 1'b1;
            fill_d               = fill_q + ptr_t'(1);
        end

        if (pop) begin
            ent_filled_d[head_q] = 1'b0;
            head_d               = head_q + ptr_t'(1);
        end

        occ_d  = occ_q + cnt_t'(grant) - cnt_t'(pop);
        pend_d = pend_q + cnt_t'(grant) - cnt_t'(rsp_fill);
        drop_d = drop_q - cnt_t'(rsp_drop);

        if (redirect) begin
            pc_d         = {redirect_pc[XLEN-1:2], 2'b00};
            head_d       = '0;
            tail_d       = '0;
            fill_d       = '0;
            occ_d        = '0;
            pend_d       = '0;
            ent_filled_d = '0;
            drop_d       = pend_q + cnt_t'(grant) + drop_q - cnt_t'(rsp_take);
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= RESET_VEC;
            head_q       <= '0;
            tail_q       <= '0;
            fill_q       <= '0;
            occ_q        <= '0;
            pend_q       <= '0;
            drop_q       <= '0;
            ent_pc_q     <= '{default: '0};
            ent_data_q   <= '{default: '0};
            ent_filled_q <= '0;
        end else begin
            pc_q         <= pc_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            fill_q       <= fill_d;
            occ_q        <= occ_d;
            pend_q       <= pend_d;
            drop_q       <= drop_d;
            ent_pc_q     <= ent_pc_d;
            ent_data_q   <= ent_data_d;
            ent_filled_q <= ent_filled_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_flushes_q, perf_flushes_d;

    // Count head transfers and redirect cycles, wrapping at 2^32
    always_comb begin
        perf_fetched_d = perf_fetched_q + 32'(pop);
        perf_flushes_d = perf_flushes_q + 32'(redirect);
    end

    // Performance counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_flushes_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_flushes_q <= perf_flushes_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushes = perf_flushes_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized variable-latency memory and PC-stream reference model.
// Perf counter checks are active when FETCH_PERF_CNT_EN is defined.
module tb_fetch_unit;

    localparam logic [31:0] RVEC   = 32'h0;
    localparam logic [15:0] RVEC16 = 16'hFFF8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushes;
    logic [31:0] perf_fetched16;
    logic [31:0] perf_flushes16;
`endif

    logic        imem_req16;
    logic [15:0] imem_addr16;
    logic        imem_gnt16 = 1'b0;
    logic        imem_rvalid16 = 1'b0;
    logic [31:0] imem_rdata16 = '0;
    logic        inst_valid16;
    logic [31:0] inst16;
    logic [15:0] inst_pc16;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .RESET_VEC(RVEC), .QDEPTH(4)) u_dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetched(perf_fetched), .perf_flushes(perf_flushes)
`endif
    );

    fetch_unit #(.XLEN(16), .RESET_VEC(RVEC16), .QDEPTH(4)) u_dut16 (
        .clk(clk), .rst(rst),
        .imem_req(imem_req16), .imem_addr(imem_addr16), .imem_gnt(imem_gnt16),
        .imem_rvalid(imem_rvalid16), .imem_rdata(imem_rdata16),
        .redirect(1'b0), .redirect_pc(16'h0),
        .inst_valid(inst_valid16), .inst(inst16), .inst_pc(inst_pc16),
        .inst_ready(1'b1)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetched(perf_fetched16), .perf_flushes(perf_flushes16)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        mq[$];
    logic [15:0] pc16_q[$];
    logic [31:0] d16_q[$];
    logic        pend16;
    logic [15:0] pend16_addr;

    int          cyc, n_cmp, n_fail, n_pops, n_redir, n_grants, first_valid;
    int          lat_min = 1, lat_max = 1, gnt_pct = 100, rdy_pct = 100;
    logic [31:0] exp_pc, exp_req;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
    endfunction

    function automatic logic [31:0] mem16(input logic [15:0] a);
        return {~a, a};
    endfunction

    task automatic release_rst();
        imem_gnt = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b0;
        redirect = 1'b0; imem_gnt16 = 1'b0; imem_rvalid16 = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        mq.delete(); pc16_q.delete(); d16_q.delete();
        pend16 = 1'b0; pend16_addr = '0;
        cyc = 0; n_pops = 0; n_redir = 0; n_grants = 0; first_valid = -1;
        exp_pc = RVEC; exp_req = RVEC;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        release_rst();
    endtask

    // one clock: drive memory/consumer, score grants and handshakes against the model
    task automatic step(input bit redir, input logic [31:0] tgt);
        req_t r;
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            r = mq.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(r.addr);
        end
        imem_gnt      = (int'($urandom_range(99)) < gnt_pct);
        inst_ready    = (int'($urandom_range(99)) < rdy_pct);
        redirect      = redir;
        redirect_pc   = tgt;
        imem_gnt16    = 1'b1;
        imem_rvalid16 = pend16;
        imem_rdata16  = mem16(pend16_addr);
        #1;
        if (imem_req && imem_gnt) begin
            n_grants++;
            n_cmp++;
            if (imem_addr !== exp_req) begin
                n_fail++;
                $display("FAIL grant_addr: got %h want %h (cyc %0d)", imem_addr, exp_req, cyc);
            end
            r.addr = imem_addr;
            r.due  = cyc + int'($urandom_range(lat_max, lat_min));
            mq.push_back(r);
            exp_req = exp_req + 32'd4;
        end
        if (inst_valid && first_valid < 0) first_valid = cyc;
        if (inst_valid && inst_ready) begin
            n_cmp++;
            if (inst_pc !== exp_pc || inst !== mem_word(exp_pc)) begin
                n_fail++;
                $display("FAIL fetch_stream: got pc %h inst %h want pc %h inst %h (cyc %0d)",
                         inst_pc, inst, exp_pc, mem_word(exp_pc), cyc);
            end
            exp_pc = exp_pc + 32'd4;
            n_pops++;
        end
        if (redir) begin
            exp_pc  = {tgt[31:2], 2'b00};
            exp_req = exp_pc;
            n_redir++;
        end
        pend16      = imem_req16 && imem_gnt16;
        pend16_addr = imem_addr16;
        if (inst_valid16) begin
            pc16_q.push_back(inst_pc16);
            d16_q.push_back(inst16);
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (inst_valid !== 1'b0 || imem_addr !== RVEC) begin
            n_fail++;
            $display("FAIL reset_during: got valid %b addr %h want 0 %h", inst_valid, imem_addr, RVEC);
        end
        release_rst();
        #1;
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== RVEC || inst_valid !== 1'b0
            || inst !== 32'h0 || inst_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_release: got req %b addr %h valid %b inst %h pc %h want 1 %h 0 0 0",
                     imem_req, imem_addr, inst_valid, inst, inst_pc, RVEC);
        end
        n_cmp++;
        if (imem_addr16 !== RVEC16 || inst_valid16 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_16: got addr %h valid %b want %h 0", imem_addr16, inst_valid16, RVEC16);
        end
    endtask

    task automatic test_stream();
        do_reset();
        lat_min = 1; lat_max = 1; gnt_pct = 100; rdy_pct = 100;
        repeat (12) step(1'b0, '0);
        n_cmp++;
        if (first_valid !== 2) begin
            n_fail++;
            $display("FAIL stream_latency: got first valid cyc %0d want 2", first_valid);
        end
        n_cmp++;
        if (n_pops !== 10) begin
            n_fail++;
            $display("FAIL stream_rate: got %0d pops want 10", n_pops);
        end
    endtask

    task automatic test_backpressure();
        int lim;
        do_reset();
        lat_min = 1; lat_max = 1; gnt_pct = 100; rdy_pct = 0;
        repeat (8) step(1'b0, '0);
        #2;
        n_cmp++;
        if (n_grants !== 4 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full: got grants %0d req %b want 4 0", n_grants, imem_req);
        end
        rdy_pct = 100;
        step(1'b0, '0);
        #2;
        n_cmp++;
        if (n_pops !== 1 || imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_reenable: got pops %0d req %b want 1 1", n_pops, imem_req);
        end
        lim = 0;
        while (n_pops < 4 && lim < 20) begin
            step(1'b0, '0);
            lim++;
        end
        n_cmp++;
        if (n_pops < 4) begin
            n_fail++;
            $display("FAIL bp_drain: got %0d pops want 4", n_pops);
        end
    endtask

    task automatic test_redirect();
        int t;
        do_reset();
        lat_min = 3; lat_max = 3; gnt_pct = 100; rdy_pct = 100;
        repeat (2) step(1'b0, '0);
        gnt_pct = 0;
        t = cyc;
        step(1'b1, 32'h103);
        first_valid = -1;
        #2;
        n_cmp++;
        if (imem_addr !== 32'h100 || inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_addr: got addr %h valid %b want 00000100 0", imem_addr, inst_valid);
        end
        gnt_pct = 100;
        repeat (12) step(1'b0, '0);
        n_cmp++;
        if (first_valid !== t + 5 || n_pops < 5) begin
            n_fail++;
            $display("FAIL redir_first: got first cyc %0d pops %0d want %0d >=5", first_valid, n_pops, t + 5);
        end
    endtask

    task automatic test_redirect_collide();
        int t;
        int g0;
        logic [31:0] tgt;
        do_reset();
        lat_min = 1; lat_max = 1; gnt_pct = 100; rdy_pct = 100;
        repeat (5) step(1'b0, '0);
        tgt = {$urandom_range(32'h0FFF_FFFF), 2'b00} | 32'h0000_1000;
        t  = cyc;
        g0 = n_grants;
        step(1'b1, tgt);
        first_valid = -1;
        #2;
        n_cmp++;
        if (n_grants !== g0 + 1 || imem_addr !== tgt || inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL collide_state: got grants %0d addr %h valid %b want %0d %h 0",
                     n_grants - g0, imem_addr, inst_valid, 1, tgt);
        end
        repeat (10) step(1'b0, '0);
        n_cmp++;
        if (first_valid !== t + 3) begin
            n_fail++;
            $display("FAIL collide_first: got cyc %0d want %0d", first_valid, t + 3);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        lat_min = 1; lat_max = 1; gnt_pct = 100; rdy_pct = 0;
        repeat (3) step(1'b0, '0);
        gnt_pct = 0;
        repeat (2) step(1'b0, '0);
        #1;
        n_cmp++;
        if (inst_valid !== 1'b1 || inst_pc !== RVEC) begin
            n_fail++;
            $display("FAIL arst_pre: got valid %b pc %h want 1 %h", inst_valid, inst_pc, RVEC);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0 || imem_addr !== RVEC) begin
            n_fail++;
            $display("FAIL arst_now: got valid %b inst %h pc %h addr %h want 0 0 0 %h",
                     inst_valid, inst, inst_pc, imem_addr, RVEC);
        end
        release_rst();
        #1;
        n_cmp++;
        if (imem_addr !== RVEC || imem_req !== 1'b1 || inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_release: got addr %h req %b valid %b want %h 1 0",
                     imem_addr, imem_req, inst_valid, RVEC);
        end
        gnt_pct = 100; rdy_pct = 100;
        repeat (6) step(1'b0, '0);
        n_cmp++;
        if (first_valid !== 2 || n_pops !== 4) begin
            n_fail++;
            $display("FAIL arst_restart: got first %0d pops %0d want 2 4", first_valid, n_pops);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        lat_min = 1; lat_max = 1; gnt_pct = 100; rdy_pct = 100;
        step(1'b1, 32'hFFFF_FFF6);
        repeat (10) step(1'b0, '0);
        n_cmp++;
        if (n_pops < 6 || exp_pc[31:28] !== 4'h0) begin
            n_fail++;
            $display("FAIL wrap32: got pops %0d next pc %h want >=6 and wrapped", n_pops, exp_pc);
        end
    endtask

    task automatic test_wrap16();
        logic [15:0] e;
        do_reset();
        repeat (8) step(1'b0, '0);
        n_cmp++;
        if (pc16_q.size() < 4) begin
            n_fail++;
            $display("FAIL wrap16_count: got %0d want >=4", pc16_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                e = RVEC16 + 16'(4 * i);
                n_cmp++;
                if (pc16_q[i] !== e || d16_q[i] !== mem16(e)) begin
                    n_fail++;
                    $display("FAIL wrap16_%0d: got pc %h inst %h want %h %h",
                             i, pc16_q[i], d16_q[i], e, mem16(e));
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] tgt;
        do_reset();
        lat_min = 1; lat_max = 5; gnt_pct = 70; rdy_pct = 60;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(99) < 3) begin
                tgt = $urandom;
                step(1'b1, tgt);
            end else begin
                step(1'b0, '0);
            end
        end
        n_cmp++;
        if (n_pops < 100) begin
            n_fail++;
            $display("FAIL random_progress: got %0d pops want >=100", n_pops);
        end
`ifdef FETCH_PERF_CNT_EN
        #2;
        n_cmp++;
        if (perf_fetched !== 32'(n_pops) || perf_flushes !== 32'(n_redir)) begin
            n_fail++;
            $display("FAIL perf_cnt: got %0d %0d want %0d %0d",
                     perf_fetched, perf_flushes, n_pops, n_redir);
        end
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_cmp = 0;
        n_fail = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_collide();
        test_async_reset();
        test_wrap();
        test_wrap16();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
